riscv_trace_fifo: RTL

//  Downstream observer of the riscv core. Captures architectural side effects each cycle:
//   - register writeback: reg_write_sig, reg_num, reg_data
//   - data-memory access: wr/rd, addr, wr_data/rd_data

---
 rtl/riscv_trace_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo: timestamps core writeback/memory side effects into a drop-on-overflow FIFO.
module riscv_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH = 16,
  parameter int TS_W = 16,
  parameter int DROP_W = 8,
  localparam int ENTRY_W = TS_W + 3 + 5 + 2 * DATA_W + ADDR_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               reg_write_sig,
  input  logic [4:0]         reg_num,
  input  logic [DATA_W-1:0]  reg_data,
  input  logic               wr,
  input  logic               rd,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_entry,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [TS_W-1:0] ts;
  logic [CW-2:0] wp, rp;
  logic rw, cap, full, pop, push, drop;
  logic [1:0] mop;
  logic [ENTRY_W-1:0] entry;
  always_comb begin
    rw = reg_write_sig && reg_num != 5'd0;
    mop = wr ? 2'b10 : rd ? 2'b01 : 2'b00;
    entry = {ts, rw, mop, rw ? reg_num : 5'd0, rw ? reg_data : {DATA_W{1'b0}},
             mop != 2'b00 ? addr : {ADDR_W{1'b0}},
             wr ? wr_data : rd ? rd_data : {DATA_W{1'b0}}};
    cap = en && (rw || wr || rd);
    full = count == CW'(DEPTH);
    pop = out_valid && out_ready;
    push = cap && (!full || pop);
    drop = cap && full && !pop;
    out_valid = count != '0;
    out_entry = mem[rp];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ts <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (clr) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        if (push && !pop) count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (drop) overflow <= 1'b1;
        if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (push && !clr) mem[wp] <= entry;
endmodule
